// File: rtl/stbuf_pkg.sv
// Shared types and helpers for the dmem store buffer: store size codes,
// the FIFO entry layout and the alignment rule.
package stbuf_pkg;

   typedef enum logic [1:0] {
      NONE = 2'b00,
      BYTE = 2'b01,
      HALF = 2'b10,
      WORD = 2'b11
   } st_size_t;

   typedef struct packed {
      logic [29:0] waddr;
      logic [31:0] data;
      logic [3:0]  be;
   } stbuf_entry_t;

   function automatic logic st_misaligned(input st_size_t size, input logic [1:0] addr);
      return ((size == HALF) && addr[0]) || ((size == WORD) && (addr != 2'b00));
   endfunction

endpackage

// File: rtl/stbuf_align.sv
// Combinational lane steering: turns a right-justified byte/half/word store
// into replicated word data plus byte enables, and flags misaligned stores.
module stbuf_align
   import stbuf_pkg::*;
(
   input  st_size_t    size,
   input  logic [1:0]  addr,
   input  logic [31:0] wd,
   output logic [3:0]  be,
   output logic [31:0] data,
   output logic        misaligned
);

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      be   = 4'b0000;
      data = 32'h0;
      unique case (size)
         BYTE: begin
            be   = 4'b0001 << addr;
            data = {4{wd[7:0]}};
         end
         HALF: begin
            be   = addr[1] ? 4'b1100 : 4'b0011;
            data = {2{wd[15:0]}};
         end
         WORD: begin
            be   = 4'b1111;
            data = wd;
         end
         default: ;
      endcase
      misaligned = st_misaligned(size, addr);
   end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write FIFO between the core store port and data memory.
// Optional store merging into the tail entry: define STBUF_MERGE_EN.
module dmem_store_buffer
   import stbuf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   input  logic        memread,
   output logic        stall,
   output logic        ld_hazard,
   output logic        misalign,
   output logic        empty,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   stbuf_entry_t  mem_q [DEPTH];
   logic [AW-1:0] head_q, tail_q;
   logic [AW:0]   count_q;
   logic          misalign_q;

   logic [3:0]    st_be;
   logic [31:0]   st_data;
   logic          st_mis;
   logic          store_ok, full, push, pop, merge;
   stbuf_entry_t  head_e;

   stbuf_align u_align (
      .size       (st_size_t'(memwrite)),
      .addr       (dataadr[1:0]),
      .wd         (writedata),
      .be         (st_be),
      .data       (st_data),
      .misaligned (st_mis)
   );

   assign store_ok = (memwrite != 2'b00) && !st_mis;
   assign full     = (count_q == FULL_CNT);
   assign pop      = mem_valid && mem_ready;
   // A same-cycle pop never frees a slot for this cycle's store: full is pre-edge.
   assign push     = store_ok && !full && !merge;
   assign stall    = store_ok && full && !merge;

`ifdef STBUF_MERGE_EN
   logic [AW-1:0] last_idx;
   stbuf_entry_t  last_e, merged_e;

   assign last_idx = tail_q - AW'(1);
   assign last_e   = mem_q[last_idx];
   // The tail is only popped when it is also the head, i.e. a single entry.
   assign merge    = store_ok && (count_q != '0) && (last_e.waddr == dataadr[31:2])
                     && !(pop && (count_q == (AW+1)'(1)));

   always_comb begin
      merged_e    = last_e;
      merged_e.be = last_e.be | st_be;
      for (int b = 0; b < 4; b++)
         if (st_be[b]) merged_e.data[8*b +: 8] = st_data[8*b +: 8];
   end
`else
   assign merge = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= (memwrite != 2'b00) && st_mis;
         if (pop)  head_q <= head_q + AW'(1);
         if (push) tail_q <= tail_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   // NOTE: entry storage is deliberately not reset; count gates every read of it.
   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= '{waddr: dataadr[31:2], data: st_data, be: st_be};
`ifdef STBUF_MERGE_EN
      else if (merge) mem_q[last_idx] <= merged_e;
`endif
   end

   always_comb begin
      ld_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (((AW+1)'(i) < count_q) && (mem_q[head_q + AW'(i)].waddr == dataadr[31:2]))
            ld_hazard = memread;
   end

   assign head_e    = mem_q[head_q];
   assign empty     = (count_q == '0);
   assign mem_valid = !empty;
   assign misalign  = misalign_q;
   assign mem_addr  = mem_valid ? {head_e.waddr, 2'b00} : 32'h0;
   assign mem_wdata = mem_valid ? head_e.data : 32'h0;
   assign mem_be    = mem_valid ? head_e.be : 4'b0000;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed self-checking bench for dmem_store_buffer; expected values are hand-derived.
// Follows STBUF_MERGE_EN to pick the expected merge behaviour.
module tb_dmem_store_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic        memread;
   logic        stall, ld_hazard, misalign, empty, mem_valid, mem_ready;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   int n_cmp = 0;
   int n_bad = 0;

   dmem_store_buffer #(.DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .dataadr   (dataadr),
      .writedata (writedata),
      .memread   (memread),
      .stall     (stall),
      .ld_hazard (ld_hazard),
      .misalign  (misalign),
      .empty     (empty),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      memwrite  = sz;
      dataadr   = a;
      writedata = d;
   endtask

   initial begin
      reset = 1'b0; memwrite = 2'b00; dataadr = '0; writedata = '0;
      memread = 1'b0; mem_ready = 1'b0;
      #3;
      check("rst_empty",     32'(empty),     32'd1);
      check("rst_valid",     32'(mem_valid), 32'd0);
      check("rst_stall",     32'(stall),     32'd0);
      check("rst_misalign",  32'(misalign),  32'd0);
      check("rst_addr",      mem_addr,       32'h0);
      check("rst_be",        32'(mem_be),    32'h0);
      tick();
      reset = 1'b1;

      // Byte store, immediate drain
      mem_ready = 1'b1;
      store(2'b01, 32'h55, 32'h0000_00AB);
      settle();
      check("sb_stall", 32'(stall), 32'd0);
      tick();
      store(2'b00, 32'h0, 32'h0);
      settle();
      check("sb_valid", 32'(mem_valid), 32'd1);
      check("sb_addr",  mem_addr,       32'h54);
      check("sb_be",    32'(mem_be),    32'b0010);
      check("sb_wdata", mem_wdata,      32'hABAB_ABAB);
      tick();
      check("sb_empty", 32'(empty), 32'd1);

      // Fill to DEPTH, stall on the fifth store
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         store(2'b11, 32'(4 * i), 32'h1000 + 32'(i));
         settle();
         check("fill_stall", 32'(stall), 32'd0);
         tick();
      end
      store(2'b11, 32'h10, 32'h1004);
      settle();
      check("full_stall",  32'(stall), 32'd1);
      check("full_head",   mem_addr,   32'h0);
      tick();
      check("hold_stall",  32'(stall), 32'd1);
      check("hold_head",   mem_addr,   32'h0);
      check("hold_wdata",  mem_wdata,  32'h1000);
      mem_ready = 1'b1;
      settle();
      check("pop_no_free", 32'(stall), 32'd1);
      tick();
      mem_ready = 1'b0;
      settle();
      check("after_pop_stall", 32'(stall), 32'd0);
      check("after_pop_head",  mem_addr,   32'h4);
      tick();
      store(2'b00, 32'h0, 32'h0);
      mem_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle();
         check("drain_valid", 32'(mem_valid), 32'd1);
         check("drain_addr",  mem_addr,       32'h4 + 32'(4 * k));
         check("drain_data",  mem_wdata,      32'h1001 + 32'(k));
         tick();
      end
      check("drain_empty", 32'(empty), 32'd1);

      // Misaligned word store is dropped; aligned half store to upper lanes
      mem_ready = 1'b0;
      store(2'b11, 32'h6, 32'hDEAD_BEEF);
      settle();
      check("mis_stall", 32'(stall), 32'd0);
      tick();
      store(2'b10, 32'h6, 32'h0000_1234);
      settle();
      check("mis_pulse", 32'(misalign), 32'd1);
      check("mis_empty", 32'(empty),    32'd1);
      tick();
      store(2'b00, 32'h0, 32'h0);
      settle();
      check("mis_clear", 32'(misalign), 32'd0);
      check("sh_addr",   mem_addr,      32'h4);
      check("sh_be",     32'(mem_be),   32'b1100);
      check("sh_wdata",  mem_wdata,     32'h1234_1234);
      mem_ready = 1'b1;
      tick();
      check("sh_empty", 32'(empty), 32'd1);

      // Load hazard against a pending store
      mem_ready = 1'b0;
      store(2'b11, 32'h58, 32'hCAFE_F00D);
      tick();
      store(2'b00, 32'h0, 32'h0);
      memread = 1'b1; dataadr = 32'h5B;
      settle();
      check("ldh_hit", 32'(ld_hazard), 32'd1);
      dataadr = 32'h5C;
      settle();
      check("ldh_miss", 32'(ld_hazard), 32'd0);
      memread = 1'b0; dataadr = 32'h58;
      settle();
      check("ldh_noread", 32'(ld_hazard), 32'd0);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check("ldh_empty", 32'(empty), 32'd1);

      // Two byte stores to the same word
      store(2'b01, 32'h20, 32'h11);
      tick();
      store(2'b01, 32'h21, 32'h22);
      tick();
      store(2'b00, 32'h0, 32'h0);
      settle();
      check("mrg_addr", mem_addr, 32'h20);
`ifdef STBUF_MERGE_EN
      check("mrg_be",    32'(mem_be),           32'b0011);
      check("mrg_wdata", {16'h0, mem_wdata[15:0]}, 32'h2211);
      mem_ready = 1'b1;
      tick();
      check("mrg_empty", 32'(empty), 32'd1);
`else
      check("nomrg_be0",    32'(mem_be), 32'b0001);
      check("nomrg_wdata0", mem_wdata,   32'h1111_1111);
      mem_ready = 1'b1;
      tick();
      check("nomrg_valid1", 32'(mem_valid), 32'd1);
      check("nomrg_addr1",  mem_addr,       32'h20);
      check("nomrg_be1",    32'(mem_be),    32'b0010);
      check("nomrg_wdata1", mem_wdata,      32'h2222_2222);
      tick();
      check("nomrg_empty", 32'(empty), 32'd1);
`endif

      // Asynchronous reset with pending entries
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         store(2'b11, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
         tick();
      end
      store(2'b00, 32'h0, 32'h0);
      settle();
      check("pre_rst_valid", 32'(mem_valid), 32'd1);
      reset = 1'b0;
      settle();
      check("async_valid", 32'(mem_valid), 32'd0);
      check("async_empty", 32'(empty),     32'd1);
      tick();
      reset = 1'b1;
      mem_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         settle();
         check("post_rst_valid", 32'(mem_valid), 32'd0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Posted-write buffer between the single-cycle core's store port (`memwrite`/`dataadr`/`writedata`) and the data memory. Accepts byte/half/word stores in one cycle, converts them to word-aligned writes with byte enables, and drains them in order over a valid/ready handshake. Gives the core back-pressure (`stall`) and a load-hazard flag for loads that hit a pending store.

## Interface
- `DEPTH`, 4: number of buffer entries, a power of 2 and at least 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memwrite`  in  2  store size code from the core: 00 none, 01 byte, 10 half, 11 word.
- `dataadr`  in  32  byte address of the store or load.
- `writedata`  in  32  store data, right-justified.
- `memread`  in  1  the core is issuing a load at `dataadr` this cycle.
- `stall`  out  1  store presented but not accepted this cycle.
- `ld_hazard`  out  1  load word address matches a valid entry.
- `misalign`  out  1  one-cycle pulse: the previous cycle's store was misaligned and was dropped.
- `empty`  out  1  no valid entries.
- `mem_valid`  out  1  head entry is presented to memory.
- `mem_ready`  in  1  memory accepts the head entry.
- `mem_addr`  out  32  word address of the head entry, bits [1:0] = 00.
- `mem_wdata`  out  32  lane-steered data of the head entry.
- `mem_be`  out  4  byte enables of the head entry.

## Operation
- Circular FIFO built from head/tail pointers of width log2(DEPTH) plus a count of width log2(DEPTH)+1. Each entry holds word address [31:2], 32-bit data and 4-bit byte enables.
- Lane steering:
  - byte: be = 1 << addr[1:0]; data = {4{wd[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011; data = {2{wd[15:0]}}.
  - word: be = 1111; data = wd.
- Misaligned stores are dropped and never enqueued, and they do not stall. A store is misaligned when:
  - it is a half store with addr[0] = 1, or
  - it is a word store with addr[1:0] ≠ 00.
- Accept condition: memwrite ≠ 00, the store is aligned, and count < DEPTH before the edge.
  - A pop in the same cycle does not free a slot for that cycle's store.
  - `stall` = (memwrite ≠ 00) & aligned & (count == DEPTH). The core holds the store while stalled.
- Pop condition: mem_valid & mem_ready. Head advances and count decrements.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- `mem_valid` = count ≠ 0. `mem_*` carry the head entry's fields directly (registered state, no combinational path from the inputs).
- `ld_hazard` = memread & OR over valid entries of (entry addr[31:2] == dataadr[31:2]). It is combinational. The core stalls the load until the flag clears.
- `empty` = count == 0.

## Timing
- Reset (asynchronous, active-low): count, pointers and misalign are cleared, so `empty` = 1, `mem_valid` = 0, `stall` = 0.
  - Entry contents are don't-care.
  - `mem_addr`, `mem_wdata` and `mem_be` read as 0 while `mem_valid` = 0.
- Reset mid-operation discards all pending stores.
- Latency: a store accepted at edge N is presented on `mem_*` in cycle N+1 when the FIFO was empty.
- With `mem_ready` held high, drain throughput is one entry per cycle.
- `mem_*` stay stable while mem_valid & !mem_ready.
- `misalign` is registered: high for exactly the cycle after the offending store.

## Configuration
- Macro: `STBUF_MERGE_EN`.
- With the macro defined, an aligned store merges into the tail entry (the most recently written one) instead of allocating a new entry when both hold:
  - its word address equals the tail entry's word address, and
  - the tail entry is not being popped that cycle.
- Merge rules:
  - be_tail |= be_new; the newly enabled lanes overwrite the tail data.
  - A merge is allowed when count == DEPTH and does not assert `stall`.
- Without the macro, every aligned store allocates a new entry.

## Structure
- Package `stbuf_pkg` holds:
  - enum `st_size_t` (NONE, BYTE, HALF, WORD);
  - struct `stbuf_entry_t` (waddr[29:0], data[31:0], be[3:0]);
  - function `st_misaligned`.
- One sub-module, `stbuf_align`: a combinational steering unit. It takes size, addr[1:0] and wd, and produces be, data and misaligned.

## Test plan
- Reset, then sb 0xAB to 0x55 with mem_ready = 1 → the next cycle shows mem_addr = 0x54, mem_be = 0010, mem_wdata = 0xABABABAB; `empty` = 1 after the pop.
- mem_ready = 0; issue 5 word stores to 0x0, 0x4, 0x8, 0xC, 0x10 → the fifth store sees `stall` = 1 and is accepted only after mem_ready pulses; memory sees the addresses in order 0x0 through 0x10.
- Word store to 0x6 → no enqueue, `misalign` = 1 for one cycle; half store to 0x6 with 0x1234 → mem_be = 1100, mem_wdata = 0x12341234.
- Pending store at 0x58, memread with dataadr = 0x5B → `ld_hazard` = 1; dataadr = 0x5C → `ld_hazard` = 0.
- `STBUF_MERGE_EN` defined, mem_ready = 0: sb 0x11 to 0x20, then sb 0x22 to 0x21 → one entry, mem_be = 0011, mem_wdata[15:0] = 0x2211. Undefined → two entries.
- Assert reset with 3 entries pending and mem_valid = 1 → `mem_valid` drops immediately (asynchronously) and `empty` = 1; nothing is written after reset is released.
